// File: rtl/mano_mem_responder_pkg.sv
// rtl/mano_mem_responder_pkg.sv - shared types and default widths for the memory responder
package mano_mem_responder_pkg;

  // Default bus widths shared with the control unit
  localparam int MANO_ADDR_W = 12;
  localparam int MANO_DATA_W = 16;

  // Responder FSM states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Latched operation type of the in-flight access
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mano_mem_responder_ram_array.sv
// rtl/mano_mem_responder_ram_array.sv - single-port synchronous word array with registered read
import mano_mem_responder_pkg::*;

module mano_ram_array #(
  parameter int ADDR_W = MANO_ADDR_W,
  parameter int DATA_W = MANO_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port and registered read port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mano_mem_responder.sv
// rtl/mano_mem_responder.sv - strobe-driven memory responder with wait states and sticky error
import mano_mem_responder_pkg::*;

module mano_mem_responder #(
  parameter int ADDR_W      = MANO_ADDR_W,
  parameter int DATA_W      = MANO_DATA_W,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Str,
  input  logic              Load,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Din,
  input  logic              ErrClr,
  output logic [DATA_W-1:0] Dout,
  output logic              Rdy,
  output logic              Busy,
  output logic              Err
);

  state_t            state;
  op_t               op;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              rdy_q;
  logic              err_q;
  logic              have_read;
  logic              exec;
  logic              we;
  logic              re;
  logic              err_set;
  logic [DATA_W-1:0] rdata;

  // Access fires on the last WAIT cycle; gating with rst_n keeps a reset edge from committing it
  assign exec = rst_n && (state == WAIT) && (cnt == 4'd0);
  assign we   = exec && (op == OP_WR);
  assign re   = exec && (op == OP_RD);

  // Collision in IDLE or any strobe during WAIT is a protocol error
  assign err_set = ((state == IDLE) && Str && Load) ||
                   ((state == WAIT) && (Str || Load));

  mano_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .addr  (addr_q),
    .wdata (din_q),
    .rdata (rdata)
  );

  // Responder FSM: accept a single strobe, count wait states, then complete
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= OP_RD;
      cnt       <= 4'd0;
      addr_q    <= '0;
      din_q     <= '0;
      rdy_q     <= 1'b0;
      have_read <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Str ^ Load) begin
            addr_q <= Addr;
            op     <= Str ? OP_WR : OP_RD;
            if (Str) din_q <= Din;
            cnt    <= 4'(WAIT_STATES);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdy_q <= 1'b1;
            state <= IDLE;
            if (op == OP_RD) have_read <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flag; a new error outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (ErrClr)  err_q <= 1'b0;
  end

  // Array read register only reaches Dout once a read has completed since reset
  assign Dout = have_read ? rdata : '0;
  assign Rdy  = rdy_q;
  assign Busy = (state == WAIT);
  assign Err  = err_q;

endmodule

// File: tb/tb_mano_mem_responder.sv
// tb/tb_mano_mem_responder.sv - directed self-checking bench for mano_mem_responder
module tb_mano_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        str2 = 0, load2 = 0, errclr2 = 0;
  logic [11:0] addr2 = 0;
  logic [15:0] din2 = 0, dout2;
  logic        rdy2, busy2, err2;

  logic        str0 = 0, load0 = 0, errclr0 = 0;
  logic [11:0] addr0 = 0;
  logic [15:0] din0 = 0, dout0;
  logic        rdy0, busy0, err0;

  logic        str3 = 0, load3 = 0, errclr3 = 0;
  logic [11:0] addr3 = 0;
  logic [15:0] din3 = 0, dout3;
  logic        rdy3, busy3, err3;

  mano_mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .Str(str2), .Load(load2), .Addr(addr2), .Din(din2),
    .ErrClr(errclr2), .Dout(dout2), .Rdy(rdy2), .Busy(busy2), .Err(err2));

  mano_mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .Str(str0), .Load(load0), .Addr(addr0), .Din(din0),
    .ErrClr(errclr0), .Dout(dout0), .Rdy(rdy0), .Busy(busy0), .Err(err0));

  mano_mem_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .Str(str3), .Load(load3), .Addr(addr3), .Din(din3),
    .ErrClr(errclr3), .Dout(dout3), .Rdy(rdy3), .Busy(busy3), .Err(err3));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_STATES=2 instance; reports busy cycles, edges to Rdy, Rdy pulses, Err seen
  task automatic access2(input logic wr, input logic [11:0] a, input logic [15:0] d,
                         output int bc, output int lat, output int nrdy, output int nerr);
    bc = 0; lat = 0; nrdy = 0; nerr = 0;
    str2 = wr; load2 = !wr; addr2 = a; din2 = d;
    tick();
    str2 = 0; load2 = 0;
    for (int i = 1; i <= 8; i++) begin
      if (busy2) bc++;
      if (rdy2) begin
        nrdy++;
        if (lat == 0) lat = i - 1;
      end
      if (err2) nerr++;
      if (i < 8) tick();
    end
  endtask

  int bc, lat, nrdy, nerr;

  initial begin
    // Reset for two cycles
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    check("rst_dout", dout2, 16'h0000);
    check("rst_rdy", rdy2, 1'b0);
    check("rst_busy", busy2, 1'b0);
    check("rst_err", err2, 1'b0);

    // Write then read 0x005 with WAIT_STATES=2
    access2(1'b1, 12'h005, 16'h1234, bc, lat, nrdy, nerr);
    check("wr_busy_cycles", bc, 3);
    check("wr_latency", lat, 3);
    check("wr_rdy_pulses", nrdy, 1);
    check("wr_err", nerr, 0);
    check("wr_dout_unchanged", dout2, 16'h0000);
    access2(1'b0, 12'h005, 16'h0000, bc, lat, nrdy, nerr);
    check("rd_busy_cycles", bc, 3);
    check("rd_latency", lat, 3);
    check("rd_rdy_pulses", nrdy, 1);
    check("rd_err", nerr, 0);
    check("rd_dout", dout2, 16'h1234);

    // Seed 0x010; a write must leave Dout alone
    access2(1'b1, 12'h010, 16'h0BEE, bc, lat, nrdy, nerr);
    check("seed_dout_held", dout2, 16'h1234);

    // Collision: both strobes in IDLE
    str2 = 1; load2 = 1; addr2 = 12'h010; din2 = 16'hDEAD;
    tick();
    str2 = 0; load2 = 0;
    check("coll_err", err2, 1'b1);
    check("coll_busy", busy2, 1'b0);
    nrdy = 0;
    for (int i = 0; i < 4; i++) begin
      if (rdy2) nrdy++;
      tick();
    end
    check("coll_no_rdy", nrdy, 0);

    // ErrClr alone clears, ErrClr with collision does not
    errclr2 = 1;
    tick();
    errclr2 = 0;
    check("errclr_clears", err2, 1'b0);
    str2 = 1; load2 = 1; errclr2 = 1;
    tick();
    str2 = 0; load2 = 0;
    check("errclr_vs_coll", err2, 1'b1);
    tick();
    errclr2 = 0;
    check("errclr_again", err2, 1'b0);

    access2(1'b0, 12'h010, 16'h0000, bc, lat, nrdy, nerr);
    check("coll_mem_intact", dout2, 16'h0BEE);

    // Overrun: write strobe one cycle into a read
    load2 = 1; addr2 = 12'h005;
    tick();
    load2 = 0; str2 = 1; din2 = 16'hFFFF;
    tick();
    str2 = 0;
    check("ovr_err", err2, 1'b1);
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      if (rdy2) nrdy++;
      tick();
    end
    check("ovr_single_rdy", nrdy, 1);
    check("ovr_dout", dout2, 16'h1234);
    errclr2 = 1;
    tick();
    errclr2 = 0;
    access2(1'b0, 12'h005, 16'h0000, bc, lat, nrdy, nerr);
    check("ovr_mem_intact", dout2, 16'h1234);

    // Back-to-back with WAIT_STATES=0, read issued in the Rdy cycle
    str0 = 1; addr0 = 12'hFFF; din0 = 16'hABCD;
    tick();
    str0 = 0;
    check("b2b_wr_busy", busy0, 1'b1);
    check("b2b_wr_rdy_early", rdy0, 1'b0);
    tick();
    check("b2b_wr_rdy", rdy0, 1'b1);
    check("b2b_wr_idle", busy0, 1'b0);
    load0 = 1; addr0 = 12'hFFF;
    tick();
    load0 = 0;
    check("b2b_rd_busy", busy0, 1'b1);
    tick();
    check("b2b_rd_rdy", rdy0, 1'b1);
    check("b2b_rd_dout", dout0, 16'hABCD);
    check("b2b_err", err0, 1'b0);

    // Reset mid-access with WAIT_STATES=3: seed 0x020, then abandon a write
    str3 = 1; addr3 = 12'h020; din3 = 16'h1111;
    tick();
    str3 = 0;
    repeat (6) tick();
    str3 = 1; addr3 = 12'h020; din3 = 16'h5555;
    tick();
    str3 = 0;
    rst_n = 0;
    tick();
    check("mid_rst_busy", busy3, 1'b0);
    check("mid_rst_rdy", rdy3, 1'b0);
    check("mid_rst_err", err3, 1'b0);
    check("mid_rst_dout", dout3, 16'h0000);
    rst_n = 1;
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      if (rdy3) nrdy++;
      tick();
    end
    check("mid_rst_no_rdy", nrdy, 0);
    load3 = 1; addr3 = 12'h020;
    tick();
    load3 = 0;
    repeat (4) tick();
    check("mid_rst_rd_rdy", rdy3, 1'b1);
    check("mid_rst_rd_dout", dout3, 16'h1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
